// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - sample/coefficient sequencer feeding a streaming FIR filter
//
// Loads TAPS coefficients into the FIR, then streams num_samples entries from
// a host-written sample buffer. Playback either stops after one pass or wraps
// continuously, and every run ends in a TAPS-long drain phase and a done pulse.
//
// Optional feature macro: FIR_SEQ_ZERO_FLUSH_EN
//   defined   - DRAIN pushes TAPS zero-valued samples through the ready/valid port
//   undefined - DRAIN idles with fir_valid low for TAPS cycles
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start, stop                   single-cycle run begin / early-end requests
//   loop_en                       wrap playback continuously while high
//   num_samples                   samples per pass (0 or > DEPTH means DEPTH)
//   buf_we/buf_addr/buf_wdata     host write port into the sample buffer
//   coef_we/coef_idx/coef_wdata   host write port into the coefficient file
//   fir_coef_we/addr/data         coefficient load port to the FIR
//   fir_data_in/fir_valid         sample stream to the FIR (registered)
//   fir_ready                     FIR accepts the current sample
//   busy/done/sample_cnt          run active, end pulse, samples accepted this pass

module fir_seq_ctrl #(
    parameter int N     = 16,
    parameter int DEPTH = 32,
    parameter int TAPS  = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(TAPS),
    localparam int SW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic [SW-1:0] num_samples,
    input  logic          buf_we,
    input  logic [AW-1:0] buf_addr,
    input  logic [N-1:0]  buf_wdata,
    input  logic          coef_we,
    input  logic [CW-1:0] coef_idx,
    input  logic [N-1:0]  coef_wdata,
    output logic          fir_coef_we,
    output logic [CW-1:0] fir_coef_addr,
    output logic [N-1:0]  fir_coef_data,
    output logic [N-1:0]  fir_data_in,
    output logic          fir_valid,
    input  logic          fir_ready,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] sample_cnt
);

`ifdef FIR_SEQ_ZERO_FLUSH_EN
    localparam bit ZERO_FLUSH = 1'b1;
`else
    localparam bit ZERO_FLUSH = 1'b0;
`endif

    localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_COEF,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [N-1:0]  buf_mem  [DEPTH];
    logic [N-1:0]  coef_mem [TAPS];

    logic [CW-1:0] coef_cnt;
    logic [CW-1:0] drain_cnt;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] rd_addr_inc;
    logic [SW-1:0] ns_reg;
    logic [SW-1:0] ns_eff;
    logic          stop_pend;
    logic          stop_req;
    logic          xfer;
    logic          last_sample;
    logic          drain_last;

    // Out-of-range pass lengths fall back to the whole buffer.
    assign ns_eff = (num_samples == '0 || num_samples > SW'(DEPTH)) ? SW'(DEPTH) : num_samples;

    assign xfer        = fir_valid && fir_ready;
    assign stop_req    = stop || stop_pend;
    assign rd_addr_inc = rd_addr + AW'(1);
    assign last_sample = ({1'b0, rd_addr} == ns_reg - SW'(1));

    // With zero flush, drain counts accepted zero samples; otherwise clock cycles.
    assign drain_last  = ZERO_FLUSH ? (xfer && drain_cnt == LAST_TAP) : (drain_cnt == LAST_TAP);

    // Host writes are only allowed while idle; contents survive reset.
    always_ff @(posedge clk) begin
        if (buf_we && !busy) begin
            buf_mem[buf_addr] <= buf_wdata;
        end
        if (coef_we && !busy) begin
            coef_mem[coef_idx] <= coef_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        busy          = (state != IDLE);
        done          = (state == DONE);
        fir_coef_we   = (state == LOAD_COEF);
        fir_coef_addr = '0;
        fir_coef_data = '0;

        if (state == LOAD_COEF) begin
            fir_coef_addr = coef_cnt;
            fir_coef_data = coef_mem[coef_cnt];
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD_COEF;
                end
            end
            LOAD_COEF: begin
                // A stop seen during the load skips streaming entirely.
                if (coef_cnt == LAST_TAP) begin
                    state_nxt = stop_req ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                // A pending sample is never abandoned: stop waits for its transfer.
                if (xfer) begin
                    if (stop_req || (last_sample && !loop_en)) begin
                        state_nxt = DRAIN;
                    end
                end else if (!fir_valid && stop_req) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coef_cnt    <= '0;
            drain_cnt   <= '0;
            rd_addr     <= '0;
            sample_cnt  <= '0;
            ns_reg      <= '0;
            stop_pend   <= 1'b0;
            fir_valid   <= 1'b0;
            fir_data_in <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        coef_cnt   <= '0;
                        drain_cnt  <= '0;
                        rd_addr    <= '0;
                        sample_cnt <= '0;
                        stop_pend  <= 1'b0;
                        ns_reg     <= ns_eff;
                    end
                end
                LOAD_COEF: begin
                    coef_cnt <= coef_cnt + CW'(1);
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    // Prefetch the first sample so STREAM starts with valid data.
                    if (state_nxt == STREAM) begin
                        fir_valid   <= 1'b1;
                        fir_data_in <= buf_mem[0];
                    end else if (state_nxt == DRAIN) begin
                        fir_valid   <= ZERO_FLUSH;
                        fir_data_in <= '0;
                        drain_cnt   <= '0;
                    end
                end
                STREAM: begin
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (xfer) begin
                        if (last_sample && loop_en && state_nxt == STREAM) begin
                            rd_addr    <= '0;
                            sample_cnt <= '0;
                        end else begin
                            rd_addr    <= rd_addr_inc;
                            sample_cnt <= sample_cnt + SW'(1);
                        end
                    end
                    // fir_data_in only moves on a transfer, so it holds during stalls.
                    if (state_nxt == DRAIN) begin
                        fir_valid   <= ZERO_FLUSH;
                        fir_data_in <= '0;
                        drain_cnt   <= '0;
                    end else if (xfer) begin
                        fir_data_in <= (last_sample && loop_en) ? buf_mem[0] : buf_mem[rd_addr_inc];
                    end
                end
                DRAIN: begin
                    if (ZERO_FLUSH) begin
                        if (xfer) begin
                            drain_cnt <= drain_cnt + CW'(1);
                            if (drain_last) begin
                                fir_valid <= 1'b0;
                            end
                        end
                    end else begin
                        drain_cnt <= drain_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 Parameters SHALL be: N, default 16, sample and coefficient width; DEPTH, default 32, sample buffer entries; TAPS, default 8, coefficient count.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  single-cycle request to begin a run.
REQ-005 stop  in  1  single-cycle request to end a run early.
REQ-006 loop_en  in  1  when high, sample playback wraps continuously.
REQ-007 num_samples  in  6  samples per pass; 0 or values above DEPTH SHALL be treated as DEPTH.
REQ-008 buf_we / buf_addr / buf_wdata  in  1 / 5 / N  host write port into the sample buffer.
REQ-009 coef_we / coef_idx / coef_wdata  in  1 / 3 / N  host write port into the coefficient register file.
REQ-010 fir_coef_we / fir_coef_addr / fir_coef_data  out  1 / 3 / N  coefficient load port to the FIR.
REQ-011 fir_data_in / fir_valid  out  N / 1  sample stream to the FIR.
REQ-012 fir_ready  in  1  FIR accepts a sample.
REQ-013 busy / done / sample_cnt  out  1 / 1 / 6  run active; one-cycle end pulse; samples accepted in the current pass.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, LOAD_COEF, STREAM, DRAIN, DONE.
REQ-015 IDLE -> LOAD_COEF on start; start in any other state SHALL be ignored.
REQ-016 LOAD_COEF SHALL assert fir_coef_we for exactly TAPS consecutive cycles, with fir_coef_addr running 0..TAPS-1 and fir_coef_data equal to the stored coefficient; it SHALL then go to STREAM.
REQ-017 In STREAM, fir_valid and fir_data_in SHALL be registered; fir_data_in SHALL equal buffer[rd_addr] and SHALL stay stable while fir_valid=1 and fir_ready=0.
REQ-018 A transfer SHALL occur only on cycles with fir_valid=1 and fir_ready=1; each transfer SHALL advance rd_addr by 1 and sample_cnt by 1.
REQ-019 After the transfer at rd_addr = num_samples-1: with loop_en=1, rd_addr and sample_cnt SHALL wrap to 0 and STREAM continues with no gap cycle; with loop_en=0, the FSM SHALL go to DRAIN.
REQ-020 A stop in STREAM SHALL be honoured after the pending transfer completes, or immediately if fir_valid=0; the FSM SHALL then go to DRAIN.
REQ-021 A stop in LOAD_COEF SHALL be latched; the coefficient load completes, STREAM is skipped, and the FSM goes to DRAIN.
REQ-022 DRAIN SHALL last exactly TAPS cycles (see REQ-029) and then go to DONE.
REQ-023 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Host buffer and coefficient writes SHALL be accepted only while busy=0 and ignored otherwise.
REQ-026 A buffer write and a start in the same IDLE cycle SHALL both take effect, and the written data SHALL be visible to the run.

Reset
REQ-027 Asserting rst SHALL immediately force the following, whatever the current state (mid-run included): state=IDLE, rd_addr=0, sample_cnt=0, fir_valid=0, fir_data_in=0, fir_coef_we=0, fir_coef_addr=0, fir_coef_data=0, busy=0, done=0, and any latched stop cleared.
REQ-028 The buffer and coefficient contents SHALL be left unchanged by reset.

Configuration
REQ-029 Macro FIR_SEQ_ZERO_FLUSH_EN:
- Defined: DRAIN SHALL drive fir_data_in=0 with fir_valid=1 until TAPS transfers complete, honouring fir_ready.
- Undefined: DRAIN SHALL hold fir_valid=0 for TAPS clock cycles.

Verification
REQ-030 Bench SHALL cover:
- Load coefs 1..8 and buffer 0..31; start with num_samples=32, loop_en=0, fir_ready=1. Expect: 8 coefficient writes at addresses 0..7, then 32 transfers with data 0..31, then DRAIN, then one done pulse.
- fir_ready toggling 1,0,0,1 during STREAM. Expect: fir_data_in stable across stalls, no samples lost or repeated.
- num_samples=4, loop_en=1, run 10 transfers. Expect: data sequence 0,1,2,3,0,1,2,3,0,1; sample_cnt wraps 3 -> 0; done never asserted.
- stop at transfer 5 with fir_ready=0 held for 2 cycles. Expect: sample 5 transferred, then DRAIN, then done; sample_cnt=6.
- rst asserted mid-STREAM. Expect: busy=0 and fir_valid=0 immediately; buffer readback unchanged; a new start replays from address 0.
- Build with and without FIR_SEQ_ZERO_FLUSH_EN, fir_ready=1. Expect: defined gives 8 zero-valued transfers; undefined gives 8 cycles with fir_valid=0.
